meter_countdown: RTL and testbench

METER_COUNTDOWN -- requirements
Module: meter_countdown

---
 rtl/meter_countdown_pkg.sv | 38 +++
 rtl/meter_bin2bcd.sv | 21 ++
 rtl/meter_countdown.sv | 97 +++++++++
 tb/tb_meter_countdown.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/meter_countdown_pkg.sv
// Shared definitions for the parking-meter countdown: state encodings, coin values,
// and helpers used by meter_countdown and the display driver.
package meter_countdown_pkg;

  localparam int unsigned TIME_W = 14;
  localparam int unsigned BCD_W  = 16;

  localparam int unsigned COIN_60  = 60;
  localparam int unsigned COIN_120 = 120;
  localparam int unsigned COIN_180 = 180;
  localparam int unsigned COIN_300 = 300;

  typedef enum logic [1:0] {
    ST_EXPIRED = 2'd0,
    ST_LOW     = 2'd1,
    ST_RUN     = 2'd2
  } meter_state_e;

  // Total credit of all coins seen in one cycle; at most 660, so 10 bits suffice.
  function automatic logic [9:0] coin_sum(input logic a60, input logic a120,
                                          input logic a180, input logic a300);
    coin_sum = (a60  ? 10'(COIN_60)  : 10'd0)
             + (a120 ? 10'(COIN_120) : 10'd0)
             + (a180 ? 10'(COIN_180) : 10'd0)
             + (a300 ? 10'(COIN_300) : 10'd0);
  endfunction

  function automatic meter_state_e state_of(input logic [TIME_W-1:0] t,
                                            input logic [TIME_W-1:0] low);
    if (t == '0)
      state_of = ST_EXPIRED;
    else if (t < low)
      state_of = ST_LOW;
    else
      state_of = ST_RUN;
  endfunction

endpackage

// File: rtl/meter_bin2bcd.sv
// Combinational double-dabble: 14-bit binary to four BCD digits (thousands in [15:12]).
module meter_bin2bcd (
  input  logic [13:0] bin,
  output logic [15:0] bcd
);

  logic [29:0] sr;

  always_comb begin
    sr = {16'b0, bin};
    for (int unsigned i = 0; i < 14; i++) begin
      for (int unsigned d = 0; d < 4; d++) begin
        if (sr[14 + 4*d +: 4] >= 4'd5)
          sr[14 + 4*d +: 4] = sr[14 + 4*d +: 4] + 4'd3;
      end
      sr = sr << 1;
    end
    bcd = sr[29:14];
  end

endmodule

// File: rtl/meter_countdown.sv
// Parking-meter countdown: coin credit, presets, 1 Hz decrement and blink control.
// Optional registered BCD output when METER_BCD_OUT_EN is defined.
module meter_countdown
  import meter_countdown_pkg::*;
#(
  parameter int unsigned MAX_TIME   = 9999,
  parameter int unsigned LOW_THRESH = 180,
  parameter int unsigned PRESET_A   = 15,
  parameter int unsigned PRESET_B   = 150
) (
  input  logic        clk_1Hz,
  input  logic        rst,
  input  logic        add_60,
  input  logic        add_120,
  input  logic        add_180,
  input  logic        add_300,
  input  logic        preset_a,
  input  logic        preset_b,
  output logic [13:0] time_left,
  output logic [1:0]  state,
  output logic        display_on,
  output logic        expired
`ifdef METER_BCD_OUT_EN
  ,
  output logic [15:0] bcd_out
`endif
);

  localparam logic [15:0]       MAX_SUM = 16'(MAX_TIME);
  localparam logic [TIME_W-1:0] MAX_T   = TIME_W'(MAX_TIME);
  localparam logic [TIME_W-1:0] LOW_T   = TIME_W'(LOW_THRESH);
  localparam logic [TIME_W-1:0] PRE_A   = TIME_W'(PRESET_A);
  localparam logic [TIME_W-1:0] PRE_B   = TIME_W'(PRESET_B);

  meter_state_e      state_q, state_nxt;
  logic [TIME_W-1:0] time_nxt;
  logic              disp_nxt;
  logic [9:0]        coins;
  logic [15:0]       sum;

  always_comb begin
    coins    = coin_sum(add_60, add_120, add_180, add_300);
    sum      = {2'b00, time_left} + {6'b0, coins};
    time_nxt = time_left;
    if (preset_b)
      time_nxt = PRE_B;
    else if (preset_a)
      time_nxt = PRE_A;
    else if (coins != '0)
      time_nxt = (sum > MAX_SUM) ? MAX_T : sum[TIME_W-1:0];
    else if (time_left != '0)
      time_nxt = time_left - 14'd1;

    // State is re-derived from the next count every edge, so an illegal
    // register value can never persist beyond one cycle.
    state_nxt = state_of(time_nxt, LOW_T);

    disp_nxt = 1'b1;
    case (state_nxt)
      ST_RUN:  disp_nxt = 1'b1;
      ST_LOW:  disp_nxt = ~time_nxt[0];
      default: disp_nxt = (state_q == ST_EXPIRED) ? ~display_on : 1'b1;
    endcase
  end

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      time_left  <= '0;
      state_q    <= ST_EXPIRED;
      display_on <= 1'b1;
    end else begin
      time_left  <= time_nxt;
      state_q    <= state_nxt;
      display_on <= disp_nxt;
    end
  end

  assign state   = state_q;
  assign expired = (state_q == ST_EXPIRED);

`ifdef METER_BCD_OUT_EN
  logic [15:0] bcd_nxt;

  meter_bin2bcd u_bin2bcd (
    .bin (time_nxt),
    .bcd (bcd_nxt)
  );

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst)
      bcd_out <= '0;
    else
      bcd_out <= bcd_nxt;
  end
`endif

endmodule

// File: tb/tb_meter_countdown.sv
// Scoreboard bench for meter_countdown: stimulus pushes expected outputs per edge,
// a monitor pops and compares one entry after each rising clock edge.
`timescale 1ns/1ps
module tb_meter_countdown;

  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] A60  = 6'b000001;
  localparam logic [5:0] A120 = 6'b000010;
  localparam logic [5:0] A180 = 6'b000100;
  localparam logic [5:0] A300 = 6'b001000;
  localparam logic [5:0] PA   = 6'b010000;
  localparam logic [5:0] PB   = 6'b100000;
  localparam logic [5:0] ALLC = 6'b001111;

  localparam int EXP = 0;
  localparam int LOW = 1;
  localparam int RUN = 2;

  logic        clk_1Hz = 1'b0;
  logic        rst = 1'b0;
  logic        add_60 = 1'b0, add_120 = 1'b0, add_180 = 1'b0, add_300 = 1'b0;
  logic        preset_a = 1'b0, preset_b = 1'b0;
  logic [13:0] time_left;
  logic [1:0]  state;
  logic        display_on;
  logic        expired;
`ifdef METER_BCD_OUT_EN
  logic [15:0] bcd_out;
`endif

  meter_countdown #(
    .MAX_TIME   (9999),
    .LOW_THRESH (180),
    .PRESET_A   (15),
    .PRESET_B   (150)
  ) dut (
    .clk_1Hz    (clk_1Hz),
    .rst        (rst),
    .add_60     (add_60),
    .add_120    (add_120),
    .add_180    (add_180),
    .add_300    (add_300),
    .preset_a   (preset_a),
    .preset_b   (preset_b),
    .time_left  (time_left),
    .state      (state),
    .display_on (display_on),
    .expired    (expired)
`ifdef METER_BCD_OUT_EN
    ,
    .bcd_out    (bcd_out)
`endif
  );

  always #5 clk_1Hz = ~clk_1Hz;

  typedef struct {
    bit          chk;
    int          tl;
    int          st;
    int          disp;
    bit          bcd_chk;
    int          bcd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic [5:0] in, input bit chk, input int tl, input int st,
                      input int disp, input bit bcd_chk = 1'b0, input int bcd = 0);
    exp_t e;
    @(negedge clk_1Hz);
    {preset_b, preset_a, add_300, add_180, add_120, add_60} = in;
    e.chk = chk; e.tl = tl; e.st = st; e.disp = disp;
    e.bcd_chk = bcd_chk; e.bcd = bcd;
    sb.push_back(e);
  endtask

  task automatic check_reset_now(input string tag);
    cmp({tag, "_time_left"}, int'(time_left), 0);
    cmp({tag, "_state"}, int'(state), EXP);
    cmp({tag, "_display_on"}, int'(display_on), 1);
    cmp({tag, "_expired"}, int'(expired), 1);
`ifdef METER_BCD_OUT_EN
    cmp({tag, "_bcd_out"}, int'(bcd_out), 0);
`endif
  endtask

  // Monitor: one expectation per rising edge, sampled 1 ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_1Hz);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          cmp("time_left", int'(time_left), e.tl);
          cmp("state", int'(state), e.st);
          cmp("display_on", int'(display_on), e.disp);
          cmp("expired", int'(expired), (e.st == EXP) ? 1 : 0);
`ifdef METER_BCD_OUT_EN
          if (e.bcd_chk)
            cmp("bcd_out", int'(bcd_out), e.bcd);
`endif
        end
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1 check_reset_now("por");
    // Inputs are ignored while reset is held.
    step(ALLC, 1, 0, EXP, 1);
    step(PB,   1, 0, EXP, 1);
    @(posedge clk_1Hz); #2 rst = 1'b0;

    step(A60,  1, 60, LOW, 1);
    step(IDLE, 1, 59, LOW, 0);
    step(IDLE, 1, 58, LOW, 1);

    step(PB | A300, 1, 150, LOW, 1);
    step(IDLE,      1, 149, LOW, 0);
    step(PA | PB,   1, 150, LOW, 1);
    step(PA | A180, 1, 15,  LOW, 0);

    for (int i = 1; i <= 13; i++)
      step(IDLE, 1, 15 - i, LOW, ((15 - i) % 2 == 0) ? 1 : 0);
    step(IDLE, 1, 1, LOW, 0);
    step(IDLE, 1, 0, EXP, 1);
    step(IDLE, 1, 0, EXP, 0);
    step(IDLE, 1, 0, EXP, 1);
    step(IDLE, 1, 0, EXP, 0);

    for (int k = 1; k <= 15; k++)
      step(ALLC, 1, 660 * k, RUN, 1);
    step(A300 | A120, 1, 9999, RUN, 1);
    step(IDLE,        1, 9998, RUN, 1);
    step(A300,        1, 9999, RUN, 1);

    step(PB,  1, 150, LOW, 1);
    step(A60, 1, 210, RUN, 1);
    for (int i = 1; i <= 30; i++)
      step(IDLE, 1, 210 - i, RUN, 1);
    step(IDLE, 1, 179, LOW, 0);
    step(A60,  1, 239, RUN, 1);

    step(PB,   1, 150, LOW, 1);
    step(A300, 1, 450, RUN, 1);
    step(A60,  1, 510, RUN, 1);
    for (int i = 1; i <= 10; i++)
      step(IDLE, 1, 510 - i, RUN, 1);
    @(posedge clk_1Hz); #3 rst = 1'b1;
    #1 check_reset_now("async");
    step(ALLC, 1, 0, EXP, 1);
    @(posedge clk_1Hz); #2 rst = 1'b0;

    step(ALLC,               1, 660,  RUN, 1, 1'b1, 16'h0660);
    step(A300 | A180 | A120, 1, 1260, RUN, 1, 1'b1, 16'h1260);
    for (int i = 1; i <= 26; i++)
      step(IDLE, 1, 1260 - i, RUN, 1, (i == 26), 16'h1234);

    for (int i = 0; i < 5 && sb.size() != 0; i++)
      @(posedge clk_1Hz);
    #3;
    cmp("scoreboard_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
